// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one serial MAC (a,b,c streamed -> a*b+c) between
// N requesters; each triple is streamed, awaited and answered with its id.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   req_valid/a/b/c          per-requester triple, requester i at [i*W +: W]
//   req_ready                one-cycle accept pulse to the granted requester
//   mac_validi, mac_data_in  word stream to the MAC (a, b, c)
//   mac_valido, mac_data_out result from the MAC
//   rsp_valid/ready          response handshake, held until rsp_ready
//   rsp_id, rsp_data, rsp_err
//                            owner id, result (0 on error), timeout flag
//   busy                     high whenever the FSM is not idle
module mac_share_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 15,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N*W-1:0] req_c,
    output logic [N-1:0]   req_ready,
    output logic           mac_validi,
    output logic [W-1:0]   mac_data_in,
    input  logic           mac_valido,
    input  logic [W-1:0]   mac_data_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [IW-1:0]  rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, SEND_A, SEND_B, SEND_C, WAIT, RESP
    } state_t;

    state_t         state_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  id_q;
    logic [W-1:0]   a_q, b_q, c_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   req_ready_q;
    logic           mac_validi_q;
    logic [W-1:0]   mac_data_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_err_q;
    logic           busy_q;

    logic           gnt_vld_d;
    logic [IW-1:0]  gnt_d;
    logic [IW-1:0]  cand;
    logic [N-1:0]   gnt_oh_d;

    // Search starts one past the last winner, so the last winner has
    // lowest priority on the next round.
    always_comb begin
        gnt_vld_d = 1'b0;
        gnt_d     = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr_q) + k) % N);
            if (!gnt_vld_d && req_valid[cand]) begin
                gnt_vld_d = 1'b1;
                gnt_d     = cand;
            end
        end
        gnt_oh_d = {{(N-1){1'b0}}, 1'b1} << gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= IW'(N - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            mac_validi_q <= 1'b0;
            mac_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Pulses and the MAC stream default low; WAIT relies on this
            // gap to restart the MAC's word phase between triples.
            req_ready_q  <= '0;
            mac_validi_q <= 1'b0;
            mac_data_q   <= '0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld_d) begin
                        req_ready_q <= gnt_oh_d;
                        a_q         <= req_a[gnt_d*W +: W];
                        b_q         <= req_b[gnt_d*W +: W];
                        c_q         <= req_c[gnt_d*W +: W];
                        id_q        <= gnt_d;
                        ptr_q       <= gnt_d;
                        busy_q      <= 1'b1;
                        state_q     <= SEND_A;
                    end
                end
                SEND_A: begin
                    mac_validi_q <= 1'b1;
                    mac_data_q   <= a_q;
                    state_q      <= SEND_B;
                end
                SEND_B: begin
                    mac_validi_q <= 1'b1;
                    mac_data_q   <= b_q;
                    state_q      <= SEND_C;
                end
                SEND_C: begin
                    mac_validi_q <= 1'b1;
                    mac_data_q   <= c_q;
                    cnt_q        <= '0;
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (mac_valido) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= mac_data_out;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign mac_validi  = mac_validi_q;
    assign mac_data_in = mac_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural 3-word MAC.
// Each scenario task checks its own expected values inline.
module tb_mac_share_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N*W-1:0] req_c = '0;
    logic [N-1:0]   req_ready;
    logic           mac_validi;
    logic [W-1:0]   mac_data_in;
    logic           mac_valido;
    logic [W-1:0]   mac_data_out;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_share_arbiter #(.N(N), .W(W), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready),
        .mac_validi(mac_validi), .mac_data_in(mac_data_in),
        .mac_valido(mac_valido), .mac_data_out(mac_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    // Serial MAC: collects a,b,c on validi, answers one cycle after c.
    // A low validi restarts the phase.
    logic         mac_en = 1'b1;
    logic         stray  = 1'b0;
    logic [1:0]   ph;
    logic [W-1:0] ma, mb, m_do;
    logic         m_vo;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 2'd0; ma <= '0; mb <= '0; m_do <= '0; m_vo <= 1'b0;
        end else begin
            m_vo <= 1'b0;
            if (mac_validi) begin
                case (ph)
                    2'd0: begin ma <= mac_data_in; ph <= 2'd1; end
                    2'd1: begin mb <= mac_data_in; ph <= 2'd2; end
                    default: begin
                        if (mac_en) begin
                            m_vo <= 1'b1;
                            m_do <= ma * mb + mac_data_in;
                        end
                        ph <= 2'd0;
                    end
                endcase
            end else begin
                ph <= 2'd0;
            end
        end
    end

    assign mac_valido   = m_vo | stray;
    assign mac_data_out = stray ? 32'hDEAD_BEEF : m_do;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c[i*W +: W] = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        mac_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Ticks until a grant pulse; g is 0 if none within the budget.
    task automatic wait_grant(output logic [N-1:0] g);
        g = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_ready != '0) begin
                g = req_ready;
                break;
            end
        end
    endtask

    // Ticks until rsp_valid; cyc is -1 if it never rises.
    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({req_ready, mac_validi, mac_data_in, rsp_valid, rsp_id,
             rsp_data, rsp_err, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got rr=%b vi=%b rv=%b busy=%b exp all 0",
                     req_ready, mac_validi, rsp_valid, busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 32'd3, 32'd4, 32'd5);
        req_valid = 4'b0001;
        tick();
        n_cmp++;
        if ({req_ready, busy} !== {4'b0001, 1'b1}) begin
            n_bad++;
            $display("FAIL t1_grant got rr=%b busy=%b exp rr=0001 busy=1",
                     req_ready, busy);
        end
        req_valid = '0;
        tick();
        n_cmp++;
        if ({req_ready, mac_validi, mac_data_in} !== {4'b0000, 1'b1, 32'd3}) begin
            n_bad++;
            $display("FAIL t1_word_a got rr=%b vi=%b d=%0d exp rr=0 vi=1 d=3",
                     req_ready, mac_validi, mac_data_in);
        end
        tick();
        n_cmp++;
        if ({mac_validi, mac_data_in} !== {1'b1, 32'd4}) begin
            n_bad++;
            $display("FAIL t1_word_b got vi=%b d=%0d exp vi=1 d=4",
                     mac_validi, mac_data_in);
        end
        tick();
        n_cmp++;
        if ({mac_validi, mac_data_in} !== {1'b1, 32'd5}) begin
            n_bad++;
            $display("FAIL t1_word_c got vi=%b d=%0d exp vi=1 d=5",
                     mac_validi, mac_data_in);
        end
        tick();
        n_cmp++;
        if ({mac_validi, mac_data_in, rsp_valid} !== {1'b0, 32'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL t1_gap got vi=%b d=%0d rv=%b exp vi=0 d=0 rv=0",
                     mac_validi, mac_data_in, rsp_valid);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 32'd17, 1'b0}) begin
            n_bad++;
            $display("FAIL t1_rsp got v=%b id=%0d d=%0d e=%b exp v=1 id=0 d=17 e=0",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL t1_idle got rv=%b busy=%b exp 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
        logic [N-1:0] g;
        int cyc;
        logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [1:0]   exp_id[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [W-1:0] exp_d [5] = '{32'd10, 32'd21, 32'd32, 32'd43, 32'd10};
        do_reset();
        for (int i = 0; i < N; i++)
            set_req(i, W'(i + 1), 32'd10, W'(i));
        req_valid = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_grant(g);
            n_cmp++;
            if (g !== exp_g[t]) begin
                n_bad++;
                $display("FAIL t2_grant%0d got=%b exp=%b", t, g, exp_g[t]);
            end
            wait_rsp(cyc);
            n_cmp++;
            if ({cyc == 5, rsp_id, rsp_data, rsp_err} !==
                {1'b1, exp_id[t], exp_d[t], 1'b0}) begin
                n_bad++;
                $display("FAIL t2_rsp%0d got cyc=%0d id=%0d d=%0d e=%b exp cyc=5 id=%0d d=%0d e=0",
                         t, cyc, rsp_id, rsp_data, rsp_err, exp_id[t], exp_d[t]);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g;
        int cyc;
        int bad;
        rsp_ready = 1'b0;
        wait_grant(g);
        n_cmp++;
        if (g !== 4'b0010) begin
            n_bad++;
            $display("FAIL t3_grant got=%b exp=0010", g);
        end
        wait_rsp(cyc);
        n_cmp++;
        if ({rsp_id, rsp_data} !== {2'd1, 32'd21}) begin
            n_bad++;
            $display("FAIL t3_rsp got id=%0d d=%0d exp id=1 d=21", rsp_id, rsp_data);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_id, req_ready} !==
                {1'b1, 32'd21, 2'd1, 4'b0000}) begin
                n_bad++;
                $display("FAIL t3_hold%0d got v=%b d=%0d id=%0d rr=%b exp v=1 d=21 id=1 rr=0",
                         i, rsp_valid, rsp_data, rsp_id, req_ready);
            end
        end
        rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0000}) begin
            n_bad++;
            $display("FAIL t3_release got rv=%b rr=%b exp rv=0 rr=0000",
                     rsp_valid, req_ready);
        end
        tick();
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL t3_next_grant got=%b exp=0100", req_ready);
        end
        req_valid = '0;
        wait_rsp(cyc);
        n_cmp++;
        if ({rsp_id, rsp_data} !== {2'd2, 32'd32}) begin
            n_bad++;
            $display("FAIL t3_drain got id=%0d d=%0d exp id=2 d=32", rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        int cyc;
        do_reset();
        mac_en = 1'b0;
        set_req(0, 32'd1, 32'd2, 32'd3);
        req_valid = 4'b0001;
        wait_grant(g);
        req_valid = '0;
        n_cmp++;
        if (g !== 4'b0001) begin
            n_bad++;
            $display("FAIL t4_grant got=%b exp=0001", g);
        end
        wait_rsp(cyc);
        n_cmp++;
        if ({cyc == 18, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL t4_timeout got cyc=%0d id=%0d d=%0d e=%b exp cyc=18 id=0 d=0 e=1",
                     cyc, rsp_id, rsp_data, rsp_err);
        end
        mac_en = 1'b1;
        set_req(1, 32'd5, 32'd6, 32'd7);
        req_valid = 4'b0010;
        wait_grant(g);
        req_valid = '0;
        n_cmp++;
        if (g !== 4'b0010) begin
            n_bad++;
            $display("FAIL t4_next_grant got=%b exp=0010", g);
        end
        wait_rsp(cyc);
        n_cmp++;
        if ({cyc == 5, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd1, 32'd37, 1'b0}) begin
            n_bad++;
            $display("FAIL t4_recover got cyc=%0d id=%0d d=%0d e=%b exp cyc=5 id=1 d=37 e=0",
                     cyc, rsp_id, rsp_data, rsp_err);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [N-1:0] g;
        int cyc;
        set_req(2, 32'hFFFF_FFFF, 32'd2, 32'd3);
        req_valid = 4'b0100;
        wait_grant(g);
        req_valid = '0;
        wait_rsp(cyc);
        n_cmp++;
        if ({g, rsp_id, rsp_data, rsp_err} !== {4'b0100, 2'd2, 32'h0000_0001, 1'b0}) begin
            n_bad++;
            $display("FAIL t5_wrap got g=%b id=%0d d=%h e=%b exp g=0100 id=2 d=00000001 e=0",
                     g, rsp_id, rsp_data, rsp_err);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g;
        int cyc;
        set_req(1, 32'd7, 32'd7, 32'd7);
        req_valid = 4'b0010;
        wait_grant(g);
        req_valid = '0;
        tick();
        n_cmp++;
        if ({g, mac_validi, mac_data_in} !== {4'b0010, 1'b1, 32'd7}) begin
            n_bad++;
            $display("FAIL t6_pre got g=%b vi=%b d=%0d exp g=0010 vi=1 d=7",
                     g, mac_validi, mac_data_in);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, mac_validi, mac_data_in, rsp_valid, rsp_id,
             rsp_data, rsp_err, busy} !== '0) begin
            n_bad++;
            $display("FAIL t6_async got rr=%b vi=%b d=%0d rv=%b busy=%b exp all 0",
                     req_ready, mac_validi, mac_data_in, rsp_valid, busy);
        end
        tick();
        rst = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if ({rsp_valid, busy, mac_validi} !== 3'b000) begin
                n_bad++;
                $display("FAIL t6_stray%0d got rv=%b busy=%b vi=%b exp 0 0 0",
                         i, rsp_valid, busy, mac_validi);
            end
        end
        set_req(0, 32'd2, 32'd3, 32'd4);
        set_req(3, 32'd1, 32'd1, 32'd1);
        req_valid = 4'b1001;
        wait_grant(g);
        req_valid = '0;
        n_cmp++;
        if (g !== 4'b0001) begin
            n_bad++;
            $display("FAIL t6_priority got=%b exp=0001", g);
        end
        wait_rsp(cyc);
        n_cmp++;
        if ({cyc == 5, rsp_id, rsp_data, rsp_err} !== {1'b1, 2'd0, 32'd10, 1'b0}) begin
            n_bad++;
            $display("FAIL t6_rsp got cyc=%0d id=%0d d=%0d e=%b exp cyc=5 id=0 d=10 e=0",
                     cyc, rsp_id, rsp_data, rsp_err);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_timeout();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
